// File: rtl/ehl_ecc_pkg.sv
// Shared widths, scrubber FSM states and codeword pack/unpack helpers for the
// ehl_ecc family. Codewords are packed {check bits, data}.
package ehl_ecc_pkg;

  localparam int CW_MAX = 64;

  function automatic int cbw_f(input int width);
    return 2 + $clog2(width);
  endfunction

  function automatic int cw_f(input int width);
    return width + cbw_f(width);
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_CHECK   = 3'd3,
    ST_WR_REQ  = 3'd4,
    ST_NEXT    = 3'd5
  } scrub_state_e;

  function automatic logic [CW_MAX-1:0] width_mask(input int width);
    return (64'd1 << width) - 64'd1;
  endfunction

  function automatic logic [CW_MAX-1:0] cw_pack(input logic [CW_MAX-1:0] cb,
                                                input logic [CW_MAX-1:0] data,
                                                input int width);
    return (cb << width) | (data & width_mask(width));
  endfunction

  function automatic logic [CW_MAX-1:0] cw_data(input logic [CW_MAX-1:0] cw, input int width);
    return cw & width_mask(width);
  endfunction

  function automatic logic [CW_MAX-1:0] cw_check(input logic [CW_MAX-1:0] cw, input int width);
    return cw >> width;
  endfunction

endpackage

// File: rtl/ehl_ecc.sv
// Combinational Hamming / SECDED generator and checker. Check bit j covers the
// Hamming positions with bit j set; the top check bit is overall parity.
module ehl_ecc
  import ehl_ecc_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit SECDED = 1'b1
) (
  input  logic                       gen,
  input  logic                       chk,
  input  logic [WIDTH-1:0]           din,
  input  logic [cbw_f(WIDTH)-1:0]    cbin,
  output logic [cbw_f(WIDTH)-1:0]    cbout,
  output logic                       single_err,
  output logic                       double_err,
  output logic [WIDTH-1:0]           se_pat_dout,
  output logic [cbw_f(WIDTH)-1:0]    se_pat_cbout
);

  localparam int CBW = cbw_f(WIDTH);
  localparam int HB  = CBW - 1;

  // Data bits occupy the non-power-of-two Hamming positions in ascending order.
  function automatic int data_pos(input int idx);
    int seen;
    int pos;
    seen = 0;
    pos  = 0;
    for (int p = 3; p < 2**HB; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (seen == idx) pos = p;
        seen++;
      end
    end
    return pos;
  endfunction

  function automatic logic [WIDTH-1:0] cov_mask(input int j);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < WIDTH; i++) m[i] = ((data_pos(i) >> j) & 1) != 0;
    return m;
  endfunction

  logic [HB-1:0]    ham_s;
  logic [HB-1:0]    syn_s;
  logic [HB-1:0]    pat_ham_s;
  logic [WIDTH-1:0] pat_d_s;
  logic             par_s;
  logic             syn_nz_s;
  logic             hit_s;
  logic             single_s;
  logic             double_s;

  // Recompute Hamming parity and map the syndrome onto a single bit position.
  always_comb begin
    ham_s     = '0;
    pat_ham_s = '0;
    pat_d_s   = '0;
    for (int j = 0; j < HB; j++) ham_s[j] = ^(din & cov_mask(j));
    syn_s = ham_s ^ cbin[HB-1:0];
    for (int j = 0; j < HB; j++) pat_ham_s[j] = (syn_s == HB'(1 << j));
    for (int i = 0; i < WIDTH; i++) pat_d_s[i] = (syn_s == HB'(data_pos(i)));
  end

  assign par_s    = SECDED ? ((^din) ^ (^cbin)) : 1'b0;
  assign syn_nz_s = |syn_s;
  assign hit_s    = |{pat_ham_s, pat_d_s};

  // An odd overall parity with a syndrome that names no real bit is uncorrectable.
  assign single_s = SECDED ? (par_s & (!syn_nz_s | hit_s)) : (syn_nz_s & hit_s);
  assign double_s = SECDED ? ((!par_s & syn_nz_s) | (par_s & syn_nz_s & !hit_s))
                           : (syn_nz_s & !hit_s);

  assign single_err   = chk & single_s;
  assign double_err   = chk & double_s;
  assign se_pat_dout  = single_err ? pat_d_s : '0;
  assign se_pat_cbout = single_err ? {SECDED & !syn_nz_s, pat_ham_s} : '0;
  assign cbout        = gen ? {(SECDED ? ^{din, ham_s} : 1'b0), ham_s} : '0;

endmodule

// File: rtl/ehl_ecc_scrub.sv
// Background SECDED scrubber: sweeps addresses 0..DEPTH-1, writes back corrected
// single-bit errors and counts/logs double errors without touching memory.
module ehl_ecc_scrub
  import ehl_ecc_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int AWIDTH = 8,
  parameter int DEPTH  = 256,
  parameter int CNTW   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    clr_cnt,
  output logic                    busy,
  output logic                    done,
  output logic                    mem_req,
  input  logic                    mem_gnt,
  output logic                    mem_we,
  output logic [AWIDTH-1:0]       mem_addr,
  output logic [cw_f(WIDTH)-1:0]  mem_wdata,
  input  logic                    mem_rvalid,
  input  logic [cw_f(WIDTH)-1:0]  mem_rdata,
  output logic [CNTW-1:0]         se_cnt,
  output logic [CNTW-1:0]         de_cnt,
  output logic [AWIDTH-1:0]       last_err_addr,
  output logic                    last_err_de,
  output logic                    irq_de
);

  localparam int                CBW       = cbw_f(WIDTH);
  localparam int                CW        = cw_f(WIDTH);
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);
  localparam logic [CNTW-1:0]   CNT_MAX   = {CNTW{1'b1}};

  function automatic logic [CNTW-1:0] cnt_upd(input logic [CNTW-1:0] cnt,
                                              input logic inc, input logic clr);
    logic [CNTW-1:0] res;
    if (clr) res = '0;
    else if (inc && (cnt != CNT_MAX)) res = cnt + CNTW'(1);
    else res = cnt;
    return res;
  endfunction

  scrub_state_e      state_r;
  scrub_state_e      state_nx_s;
  logic [AWIDTH-1:0] addr_r;
  logic              abort_r;
  logic [CW-1:0]     rdata_r;
  logic [WIDTH-1:0]  ecc_din_s;
  logic [CBW-1:0]    ecc_cbin_s;
  logic [CBW-1:0]    ecc_cbout_s;
  logic [WIDTH-1:0]  pat_d_s;
  logic [CBW-1:0]    pat_cb_s;
  logic              ecc_se_s;
  logic              ecc_de_s;
  logic [CW-1:0]     fix_cw_s;
  logic              se_inc_s;
  logic              de_inc_s;
  logic              sweep_end_s;
  logic              cbout_unused_s;

  assign ecc_din_s  = WIDTH'(cw_data(CW_MAX'(rdata_r), WIDTH));
  assign ecc_cbin_s = CBW'(cw_check(CW_MAX'(rdata_r), WIDTH));
  assign fix_cw_s   = CW'(cw_pack(CW_MAX'(ecc_cbin_s ^ pat_cb_s), CW_MAX'(ecc_din_s ^ pat_d_s), WIDTH));

  ehl_ecc #(.WIDTH(WIDTH), .SECDED(1'b1)) u_ecc (
    .gen          (1'b0),
    .chk          (1'b1),
    .din          (ecc_din_s),
    .cbin         (ecc_cbin_s),
    .cbout        (ecc_cbout_s),
    .single_err   (ecc_se_s),
    .double_err   (ecc_de_s),
    .se_pat_dout  (pat_d_s),
    .se_pat_cbout (pat_cb_s)
  );

  assign cbout_unused_s = ^ecc_cbout_s;

  // Next-state logic; an abort on the NEXT cycle itself also ends the sweep.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE:    if (start) state_nx_s = ST_RD_REQ; else state_nx_s = ST_IDLE;
      ST_RD_REQ:  if (mem_gnt) state_nx_s = ST_RD_WAIT; else state_nx_s = ST_RD_REQ;
      ST_RD_WAIT: if (mem_rvalid) state_nx_s = ST_CHECK; else state_nx_s = ST_RD_WAIT;
      ST_CHECK:   if (ecc_se_s) state_nx_s = ST_WR_REQ; else state_nx_s = ST_NEXT;
      ST_WR_REQ:  if (mem_gnt) state_nx_s = ST_NEXT; else state_nx_s = ST_WR_REQ;
      ST_NEXT: begin
        if ((addr_r == LAST_ADDR) || abort_r || abort) state_nx_s = ST_IDLE;
        else state_nx_s = ST_RD_REQ;
      end
      default:    state_nx_s = ST_IDLE;
    endcase
  end

  assign se_inc_s    = (state_r == ST_CHECK) && ecc_se_s;
  assign de_inc_s    = (state_r == ST_CHECK) && ecc_de_s;
  assign sweep_end_s = (state_r == ST_NEXT) && (state_nx_s == ST_IDLE);
  assign mem_addr    = addr_r;

  // State, datapath and registered outputs; outputs decode the upcoming state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      addr_r        <= '0;
      abort_r       <= 1'b0;
      rdata_r       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_wdata     <= '0;
      se_cnt        <= '0;
      de_cnt        <= '0;
      last_err_addr <= '0;
      last_err_de   <= 1'b0;
      irq_de        <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy    <= (state_nx_s != ST_IDLE);
      done    <= sweep_end_s;
      mem_req <= (state_nx_s == ST_RD_REQ) || (state_nx_s == ST_WR_REQ);
      mem_we  <= (state_nx_s == ST_WR_REQ);
      irq_de  <= de_inc_s;
      se_cnt  <= cnt_upd(se_cnt, se_inc_s, clr_cnt);
      de_cnt  <= cnt_upd(de_cnt, de_inc_s, clr_cnt);

      if ((state_r == ST_IDLE) && start) addr_r <= '0;
      else if ((state_r == ST_NEXT) && (state_nx_s == ST_RD_REQ)) addr_r <= addr_r + AWIDTH'(1);

      if ((state_nx_s == ST_IDLE) || (state_r == ST_IDLE)) abort_r <= 1'b0;
      else if (abort) abort_r <= 1'b1;

      if ((state_r == ST_RD_WAIT) && mem_rvalid) rdata_r <= mem_rdata;
      if (se_inc_s) mem_wdata <= fix_cw_s;

      if (se_inc_s || de_inc_s) begin
        last_err_addr <= addr_r;
        last_err_de   <= de_inc_s;
      end
    end
  end

endmodule
